eth_pkt_loop_buf: RTL and testbench

Single-clock packet store-and-forward buffer for the Ethernet UDP loopback path. It sits between the UDP receive side (rec_en / rec_data / rec_pkt_done / rec_byte_num) and the UDP transmit side (tx_start_en / tx_req / tx_data / tx_done). It replaces the single-packet FIFO plus pulse synchroniser with a parametrised word RAM and a descriptor queue. Several packets can be queued, and bad or overflowing packets are dropped whole.

---
 rtl/eth_loop_pkg.sv | 28 ++
 rtl/eth_loop_ram.sv | 41 ++++
 rtl/eth_pkt_loop_buf.sv | 219 +++++++++++++++++++++
 tb/tb_eth_pkt_loop_buf.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_loop_pkg.sv
// Shared types and helpers for the Ethernet UDP loopback packet buffer.
package eth_loop_pkg;

    // Read-side FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2,
        WAIT  = 2'd3
    } loop_state_e;

    // Number of data words needed to hold byte_num bytes (ceiling division)
    function automatic int unsigned words_of(input int unsigned byte_num,
                                             input int unsigned bpw);
        return (byte_num + bpw - 1) / bpw;
    endfunction

    // Pointer width with one extra wrap bit so full and empty are distinguishable
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Index width for a power-of-two array (at least one bit)
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/eth_loop_ram.sv
// Simple dual-port word RAM: synchronous write, registered read that holds
// its value when no read is requested.
module eth_loop_ram
    import eth_loop_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2048,
    parameter int AW     = idx_w(DEPTH)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; output clears on reset and holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/eth_pkt_loop_buf.sv
// Store-and-forward packet buffer for the UDP loopback path. Packets are
// written to a word RAM and committed to a descriptor queue only when they
// arrive intact; the read FSM replays committed packets to the transmitter.
// Optional feature macro: LOOP_STAT_EN adds drop_cnt / pass_cnt outputs.
module eth_pkt_loop_buf
    import eth_loop_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 2048,
    parameter int PKT_DEPTH = 8,
    parameter int LEN_W     = 16
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rec_en,
    input  logic [DATA_W-1:0]          rec_data,
    input  logic                       rec_pkt_done,
    input  logic [LEN_W-1:0]           rec_byte_num,
    output logic                       tx_start_en,
    output logic [LEN_W-1:0]           tx_byte_num,
    input  logic                       tx_req,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_done,
    output logic [$clog2(PKT_DEPTH):0] pkt_cnt,
    output logic                       pkt_drop
`ifdef LOOP_STAT_EN
    ,
    output logic [15:0]                drop_cnt,
    output logic [15:0]                pass_cnt
`endif
);

    localparam int          AW  = idx_w(DEPTH);
    localparam int          PW  = ptr_w(DEPTH);
    localparam int          QW  = idx_w(PKT_DEPTH);  // PKT_DEPTH must be >= 2
    localparam int          CW  = $clog2(PKT_DEPTH) + 1;
    localparam int unsigned BPW = DATA_W / 8;

    // ---------------- write side ----------------
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, wr_base_q, wr_base_d, rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] wcnt_q, wcnt_d, wcnt_now;
    logic             bad_q, bad_d, bad_now;
    logic             space_ok, wr_en, commit, drop, pop, rd_en;
    logic             pkt_drop_q;
    logic [CW-1:0]    pkt_cnt_q;
    logic             desc_full;
    logic [PW-1:0]    used;

    assign used      = wr_ptr_q - rd_ptr_q;
    assign space_ok  = (used != PW'(DEPTH));
    assign wr_en     = rec_en && !bad_q && space_ok;
    assign bad_now   = bad_q || (rec_en && !space_ok);
    assign wcnt_now  = wcnt_q + LEN_W'(wr_en);
    assign desc_full = (pkt_cnt_q == CW'(PKT_DEPTH));
    // A word arriving with rec_pkt_done is already folded into wcnt_now/bad_now
    assign commit    = rec_pkt_done && !bad_now && !desc_full && (rec_byte_num != '0)
                       && (wcnt_now == LEN_W'(words_of(32'(rec_byte_num), BPW)));
    assign drop      = rec_pkt_done && !commit;

    // Next-state for write pointer, packet base, word count and bad flag
    always_comb begin
        wr_ptr_d  = wr_ptr_q + PW'(wr_en);
        wr_base_d = wr_base_q;
        wcnt_d    = wcnt_now;
        bad_d     = bad_now;
        if (rec_pkt_done) begin
            wcnt_d = '0;
            bad_d  = 1'b0;
            if (commit) begin
                wr_base_d = wr_ptr_d;
            end else begin
                wr_ptr_d = wr_base_q;  // rewind: discard the whole packet
            end
        end
    end

    // Write-side registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            wr_base_q  <= '0;
            wcnt_q     <= '0;
            bad_q      <= 1'b0;
            pkt_drop_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            wr_base_q  <= wr_base_d;
            wcnt_q     <= wcnt_d;
            bad_q      <= bad_d;
            pkt_drop_q <= drop;
        end
    end

    // ---------------- descriptor queue ----------------
    logic [LEN_W-1:0] desc_mem_q [PKT_DEPTH];
    logic [QW-1:0]    head_q, tail_q;
    logic [LEN_W-1:0] desc_head;

    assign desc_head = desc_mem_q[head_q];

    // Descriptor storage (no reset needed, guarded by the count)
    always_ff @(posedge clk) begin
        if (commit) begin
            desc_mem_q[tail_q] <= rec_byte_num;
        end
    end

    // Queue pointers and occupancy; simultaneous push and pop cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            pkt_cnt_q <= '0;
        end else begin
            if (commit) tail_q <= tail_q + QW'(1);
            if (pop)    head_q <= head_q + QW'(1);
            pkt_cnt_q <= pkt_cnt_q + CW'(commit) - CW'(pop);
        end
    end

    // ---------------- read side FSM ----------------
    loop_state_e      state_q, state_d;
    logic [LEN_W-1:0] rcnt_q, rcnt_d, tx_len_q, tx_len_d;

    // Next-state, read strobe and descriptor pop
    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        tx_len_d = tx_len_q;
        rd_ptr_d = rd_ptr_q;
        rd_en    = 1'b0;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pkt_cnt_q != '0) begin
                    tx_len_d = desc_head;
                    rcnt_d   = LEN_W'(words_of(32'(desc_head), BPW));
                    state_d  = START;
                end
            end
            START: state_d = SEND;
            SEND: begin
                if (tx_done) begin
                    // Early end: skip the words the transmitter never asked for
                    rd_ptr_d = rd_ptr_q + PW'(rcnt_q);
                    rcnt_d   = '0;
                    pop      = 1'b1;
                    state_d  = IDLE;
                end else if (tx_req && (rcnt_q != '0)) begin
                    rd_en    = 1'b1;
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    rcnt_d   = rcnt_q - LEN_W'(1);
                    if (rcnt_q == LEN_W'(1)) state_d = WAIT;
                end
            end
            WAIT: begin
                if (tx_done) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-side registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rcnt_q   <= '0;
            tx_len_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            tx_len_q <= tx_len_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    eth_loop_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (rec_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (tx_data)
    );

    assign tx_start_en = (state_q == START);
    assign tx_byte_num = tx_len_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign pkt_drop    = pkt_drop_q;

`ifdef LOOP_STAT_EN
    logic [15:0] drop_cnt_q, pass_cnt_q;

    // Saturating drop / pass statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            pass_cnt_q <= '0;
        end else begin
            if (drop && (drop_cnt_q != 16'hFFFF))   drop_cnt_q <= drop_cnt_q + 16'd1;
            if (commit && (pass_cnt_q != 16'hFFFF)) pass_cnt_q <= pass_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign pass_cnt = pass_cnt_q;
`endif

endmodule

// File: tb/tb_eth_pkt_loop_buf.sv
// Scoreboard bench for eth_pkt_loop_buf (DEPTH=32, PKT_DEPTH=4, DATA_W=32).
// Build with LOOP_STAT_EN defined to also check the statistics counters.
module tb_eth_pkt_loop_buf;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 32;
    localparam int PKT_DEPTH = 4;
    localparam int LEN_W     = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rec_en;
    logic [DATA_W-1:0] rec_data;
    logic              rec_pkt_done;
    logic [LEN_W-1:0]  rec_byte_num;
    logic              tx_start_en;
    logic [LEN_W-1:0]  tx_byte_num;
    logic              tx_req;
    logic [DATA_W-1:0] tx_data;
    logic              tx_done;
    logic [2:0]        pkt_cnt;
    logic              pkt_drop;
`ifdef LOOP_STAT_EN
    logic [15:0]       drop_cnt;
    logic [15:0]       pass_cnt;
`endif

    eth_pkt_loop_buf #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .PKT_DEPTH (PKT_DEPTH),
        .LEN_W     (LEN_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rec_en       (rec_en),
        .rec_data     (rec_data),
        .rec_pkt_done (rec_pkt_done),
        .rec_byte_num (rec_byte_num),
        .tx_start_en  (tx_start_en),
        .tx_byte_num  (tx_byte_num),
        .tx_req       (tx_req),
        .tx_data      (tx_data),
        .tx_done      (tx_done),
        .pkt_cnt      (pkt_cnt),
        .pkt_drop     (pkt_drop)
`ifdef LOOP_STAT_EN
        ,
        .drop_cnt     (drop_cnt),
        .pass_cnt     (pass_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks_n = 0;
    int fail_n   = 0;
    int start_cnt = 0;
    int starts_used = 0;
    int exp_cnt = 0;
    int exp_drops = 0;
    int exp_pass = 0;
    logic [DATA_W-1:0] exp_q [$];
    int                len_q [$];

    // Count start pulses so a pulse that fires while the bench is busy is not lost
    always @(posedge clk) begin
        if (tx_start_en) start_cnt <= start_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one packet; done_sep puts rec_pkt_done in its own cycle
    task automatic send_pkt(input int nbytes, input int nwords, input bit done_sep, input bit exp_drop);
        for (int i = 0; i < nwords; i++) begin
            rec_en       = 1'b1;
            rec_data     = $urandom();
            rec_pkt_done = !done_sep && (i == nwords - 1);
            rec_byte_num = LEN_W'(nbytes);
            if (!exp_drop) exp_q.push_back(rec_data);
            tick();
        end
        if (done_sep) begin
            rec_en       = 1'b0;
            rec_pkt_done = 1'b1;
            rec_byte_num = LEN_W'(nbytes);
            tick();
        end
        rec_en       = 1'b0;
        rec_pkt_done = 1'b0;
        check_eq("pkt_drop", 64'(pkt_drop), 64'(exp_drop));
        if (exp_drop) begin
            exp_drops++;
        end else begin
            len_q.push_back(nbytes);
            exp_cnt++;
            exp_pass++;
        end
        check_eq("pkt_cnt_wr", 64'(pkt_cnt), 64'(exp_cnt));
        $display("rx pkt bytes=%0d words=%0d drop=%0d pkt_cnt=%0d", nbytes, nwords, pkt_drop, pkt_cnt);
    endtask

    // Act as the transmitter for one packet; flush_after>=0 ends it early
    task automatic recv_pkt(input int flush_after);
        int n = 0;
        int exp_len;
        int nw;
        logic [DATA_W-1:0] last = '0;
        while ((start_cnt == starts_used) && (n < 200)) begin
            tick();
            n++;
        end
        check_eq("start_seen", 64'(start_cnt != starts_used), 64'd1);
        if (start_cnt == starts_used) return;
        starts_used++;
        exp_len = len_q.pop_front();
        check_eq("tx_byte_num", 64'(tx_byte_num), 64'(exp_len));
        nw = (exp_len + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            if ((flush_after >= 0) && (i >= flush_after)) begin
                void'(exp_q.pop_front());
            end else begin
                tx_req = 1'b1;
                tick();
                tx_req = 1'b0;
                last = exp_q.pop_front();
                check_eq("tx_data", 64'(tx_data), 64'(last));
            end
        end
        if (flush_after < 0) begin
            tx_req = 1'b1;  // extra request once all words are out must be ignored
            tick();
            tx_req = 1'b0;
            check_eq("tx_hold", 64'(tx_data), 64'(last));
        end
        check_eq("tx_len_hold", 64'(tx_byte_num), 64'(exp_len));
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        exp_cnt--;
        check_eq("pkt_cnt_rd", 64'(pkt_cnt), 64'(exp_cnt));
        check_eq("done_gap", 64'(tx_start_en), 64'd0);
        $display("tx pkt bytes=%0d words=%0d flush_after=%0d pkt_cnt=%0d", exp_len, nw, flush_after, pkt_cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        rec_en = 1'b0; rec_data = '0; rec_pkt_done = 1'b0; rec_byte_num = '0;
        tx_req = 1'b0; tx_done = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check_eq("rst_tx_start_en", 64'(tx_start_en), 64'd0);
        check_eq("rst_tx_byte_num", 64'(tx_byte_num), 64'd0);
        check_eq("rst_tx_data", 64'(tx_data), 64'd0);
        check_eq("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check_eq("rst_pkt_drop", 64'(pkt_drop), 64'd0);

        // Reset in the middle of traffic discards queued and partial data
        send_pkt(12, 3, 1'b0, 1'b0);
        rec_en = 1'b1; rec_data = 32'hDEAD_BEEF; rec_byte_num = 16'd20;
        tick(); tick();
        rst_n = 1'b0;
        rec_en = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        exp_q.delete(); len_q.delete();
        exp_cnt = 0; exp_drops = 0; exp_pass = 0;
        tick();
        check_eq("rst_mid_pkt_cnt", 64'(pkt_cnt), 64'd0);
        tick(); tick();
        check_eq("rst_mid_idle", 64'(tx_start_en), 64'd0);
        starts_used = start_cnt;

        // Single 18-byte packet: start pulse two cycles after rec_pkt_done
        send_pkt(18, 5, 1'b0, 1'b0);
        check_eq("start_early", 64'(tx_start_en), 64'd0);
        tick();
        check_eq("start_latency", 64'(tx_start_en), 64'd1);
        recv_pkt(-1);

        // Three packets queued while the transmitter is stalled
        send_pkt(32, 8, 1'b0, 1'b0);
        send_pkt(32, 8, 1'b1, 1'b0);
        send_pkt(30, 8, 1'b0, 1'b0);
        check_eq("stall_pkt_cnt", 64'(pkt_cnt), 64'd3);
        for (int i = 0; i < 3; i++) recv_pkt(-1);

        // Word-count mismatches and zero length are dropped whole
        send_pkt(20, 4, 1'b0, 1'b1);
        tick();
        check_eq("drop_pulse_len", 64'(pkt_drop), 64'd0);
        send_pkt(20, 6, 1'b1, 1'b1);
        send_pkt(0, 1, 1'b0, 1'b1);
        send_pkt(20, 5, 1'b0, 1'b0);
        recv_pkt(-1);

        // Overflow drops the packet; full capacity is available afterwards
        send_pkt(160, 40, 1'b0, 1'b1);
        send_pkt(128, 32, 1'b0, 1'b0);
        recv_pkt(-1);
        send_pkt(32, 8, 1'b0, 1'b0);
        recv_pkt(-1);

        // Descriptor queue full: fifth short packet is dropped
        for (int i = 0; i < 5; i++) send_pkt(8, 2, (i % 2) == 1, i == 4);
        check_eq("full_pkt_cnt", 64'(pkt_cnt), 64'd4);
        for (int i = 0; i < 4; i++) recv_pkt(-1);

        // Early tx_done flushes the remainder; next packet starts clean
        send_pkt(18, 5, 1'b0, 1'b0);
        send_pkt(12, 3, 1'b0, 1'b0);
        recv_pkt(2);
        recv_pkt(-1);

`ifdef LOOP_STAT_EN
        check_eq("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
        check_eq("pass_cnt", 64'(pass_cnt), 64'(exp_pass));
`endif
        check_eq("end_pkt_cnt", 64'(pkt_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
        $finish;
    end

endmodule
